uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among N_REQ byte producers. It accepts one byte at a time over a valid/ready handshake and drives the transmitter's start/data/parity-select inputs. Frame completion is tracked by counting baud ticks, and the next requester is granted only after the frame is done. It sits between the client logic and the UART transmitter, on the same clk and baud_tick as the transmitter.

## Interface
- N_REQ, 4: number of requesters, 2..8
- FRAME_TICKS, 12: baud_tick pulses from tx_start to the end of the stop bit, 1..255
- GAP_TICKS, 2: idle baud ticks inserted between frames (used only with UART_SCHED_GAP_EN), 0..255
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i]
- req_psel  in  N_REQ  parity select per requester (1 = even, 0 = odd)
- req_ready  out  N_REQ  one-hot one-cycle accept pulse
- baud_tick  in  1  one-clk pulse per bit period, shared with the transmitter
- tx_start  out  1  one-clk start pulse to the transmitter
- tx_data  out  8  byte to transmit, held for the whole frame
- tx_psel  out  1  parity select, held for the whole frame
- busy  out  1  high from accept until return to IDLE
- grant_id  out  clog2(N_REQ)  index of the current or last granted requester

## Operation
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from ptr+1, wrapping modulo N_REQ.
  - Pulse req_ready[i] for that requester, latch req_data[i] into tx_data and req_psel[i] into tx_psel, set grant_id = i and ptr = i, go to LAUNCH.
- LAUNCH:
  - Assert tx_start for exactly this cycle.
  - Clear tick_cnt, go to WAIT.
- WAIT:
  - On each baud_tick, increment tick_cnt.
  - When a tick arrives with tick_cnt == FRAME_TICKS-1, the frame is done. Go to GAP if the gap feature is compiled in and GAP_TICKS > 0; otherwise go to IDLE.
- GAP:
  - Count GAP_TICKS baud ticks, then go to IDLE.
- Fairness: a requester that holds valid continuously is re-granted only after every other active requester has been served once.
- Requester rules:
  - Must hold req_valid and its data stable until req_ready.
  - Dropping valid before ready is legal and withdraws the request.
- req_valid is ignored outside IDLE. No request is lost; it simply waits.
- tick_cnt is 8 bits and never wraps: the terminal compare ends the count first.

## Timing
- Reset values: req_ready = 0, tx_start = 0, tx_data = 8'h00, tx_psel = 0, busy = 0, grant_id = 0, ptr = N_REQ-1 (so requester 0 wins first), state = IDLE, counters = 0.
- Latency: req_valid high in IDLE → req_ready on the same edge's registered output (1 clk) → tx_start one clk after req_ready.
- A baud_tick coinciding with tx_start (the LAUNCH cycle) is not counted.
- busy rises with req_ready. busy falls on the clk after the terminal tick (or after the last gap tick).
- Back-to-back frames with no gap: the next req_ready can occur 1 clk after busy falls. The minimum frame-to-frame spacing is FRAME_TICKS ticks + 2 clk.
- Reset asserted mid-frame: all outputs return to reset values immediately and the frame is abandoned. The transmitter has its own reset, so the line is not left mid-frame.
- tx_data and tx_psel change only on accept.

## Configuration
- UART_SCHED_GAP_EN defined:
  - The GAP state and gap counter are present.
  - GAP_TICKS idle bit periods are guaranteed between frames, for receivers that need re-sync time.
- Not defined:
  - GAP is not compiled in and GAP_TICKS is ignored.
  - WAIT goes directly to IDLE.

## Structure
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE/LAUNCH/WAIT/GAP),
  - the default FRAME_TICKS constant, matching the transmitter's frame of start + 8 data + parity + stop plus one entry tick,
  - parity-select encodings.
- One sub-module: uart_rr_pick. It is combinational: takes req_valid and ptr, and returns a one-hot grant plus its index.
- The FSM, counters and output registers stay in uart_tx_sched.

## Test plan
- Single request: valid[2] = 1, data 8'hA5, psel = 1 → ready[2] pulse, tx_start one clk later, tx_data = A5, tx_psel = 1, busy low exactly FRAME_TICKS ticks + 1 clk after tx_start.
- All four valid continuously, distinct bytes 11/22/33/44 → grant order 0, 1, 2, 3, 0; each tx_start separated by ≥ FRAME_TICKS ticks.
- Requester 1 drops valid before grant while 3 holds → 3 is granted and nothing is sent for 1.
- baud_tick forced high in the LAUNCH cycle → that tick is not counted and the frame still spans FRAME_TICKS further ticks.
- rst pulled low at tick 5 of a frame → all outputs 0 asynchronously. After release, requester 0 wins first.
- With UART_SCHED_GAP_EN and GAP_TICKS = 2 → exactly 2 extra ticks between busy-driven frames. Without the macro → 0 extra ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - sched_state_t : scheduler FSM encoding (IDLE/LAUNCH/WAIT/GAP)
//   - FRAME_TICKS_DEFAULT : baud ticks from tx_start to end of stop bit
//   - PSEL_EVEN / PSEL_ODD : parity-select encodings seen by the transmitter
//   - rr_wrap() : modulo-N wrap for round-robin index arithmetic
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_t;

  // Start + 8 data + parity + stop, plus the tick on which the transmitter
  // registers the start request.
  localparam int FRAME_TICKS_DEFAULT = 12;

  localparam logic PSEL_EVEN = 1'b1;
  localparam logic PSEL_ODD  = 1'b0;

  // Single-subtract wrap: callers guarantee v < 2*n.
  function automatic logic [31:0] rr_wrap(input logic [31:0] v, input logic [31:0] n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Searches req_valid upward starting at
// ptr+1 (wrapping modulo N_REQ) and returns the first requester found.
// Ports:
//   req_valid  [N_REQ]   requests to arbitrate
//   ptr        [IDX_W]   index of the last requester served
//   grant      [N_REQ]   one-hot grant (all zero when nothing is valid)
//   grant_idx  [IDX_W]   index of the granted requester
//   grant_vld            any requester granted
// ---------------------------------------------------------------------------
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_vld
);

  localparam int IDX_W = $clog2(N_REQ);

  // cand_idx[d] is the requester at search distance d+1 from ptr.
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'(rr_wrap(32'(ptr) + 32'(gi) + 32'd1, 32'(N_REQ)));
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
      assign grant[gi]    = grant_vld && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Walk from the far end down so the nearest hit is the last assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int d = N_REQ - 1; d >= 0; d--) begin
      if (cand_hit[d]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx[d];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter among N_REQ producers.
// One byte is accepted per frame; the next grant waits until the frame's
// baud ticks (and optional inter-frame gap) have elapsed.
// Optional feature macro: UART_SCHED_GAP_EN (adds GAP state + gap counter).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  [N_REQ]    per-requester byte available
//   req_data   [8*N_REQ]  byte i at [8i+7:8i]
//   req_psel   [N_REQ]    parity select per requester (1 = even)
//   req_ready  [N_REQ]    one-hot one-cycle accept pulse
//   baud_tick             one-clk pulse per bit period
//   tx_start              one-clk start pulse to the transmitter
//   tx_data    [8]        byte being transmitted, held for the frame
//   tx_psel               parity select, held for the frame
//   busy                  accept through return to IDLE
//   grant_id   [IDX_W]    current or last granted requester
// ---------------------------------------------------------------------------
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int FRAME_TICKS = FRAME_TICKS_DEFAULT,
  parameter int GAP_TICKS   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_psel,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     baud_tick,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     tx_psel,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(N_REQ);

`ifdef UART_SCHED_GAP_EN
  localparam bit GAP_BUILD = 1'b1;
`else
  localparam bit GAP_BUILD = 1'b0;
`endif

  sched_state_t     state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [7:0]       tick_cnt_reg;
`ifdef UART_SCHED_GAP_EN
  logic [7:0]       gap_cnt_reg;
`endif
  logic [N_REQ-1:0] req_ready_reg;
  logic             tx_start_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_psel_reg;
  logic             busy_reg;
  logic [IDX_W-1:0] grant_id_reg;

  logic [7:0]       req_byte [N_REQ];
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IDX_W'(N_REQ - 1);
      tick_cnt_reg  <= '0;
`ifdef UART_SCHED_GAP_EN
      gap_cnt_reg   <= '0;
`endif
      req_ready_reg <= '0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      tx_psel_reg   <= PSEL_ODD;
      busy_reg      <= 1'b0;
      grant_id_reg  <= '0;
    end else begin
      req_ready_reg <= '0;
      tx_start_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_vld) begin
            req_ready_reg <= pick_grant;
            tx_data_reg   <= req_byte[pick_idx];
            tx_psel_reg   <= req_psel[pick_idx];
            grant_id_reg  <= pick_idx;
            ptr_reg       <= pick_idx;
            busy_reg      <= 1'b1;
            state_reg     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tx_start_reg <= 1'b1;
          tick_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          // The tick seen alongside tx_start belongs to the transmitter's
          // start handshake, not to the frame.
          if (baud_tick && !tx_start_reg) begin
            if (tick_cnt_reg == 8'(FRAME_TICKS - 1)) begin
              tick_cnt_reg <= '0;
              if (GAP_BUILD && (GAP_TICKS > 0)) begin
                state_reg <= ST_GAP;
`ifdef UART_SCHED_GAP_EN
                gap_cnt_reg <= '0;
`endif
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 8'd1;
            end
          end
        end
`ifdef UART_SCHED_GAP_EN
        ST_GAP: begin
          if (baud_tick) begin
            if (gap_cnt_reg == 8'(GAP_TICKS - 1)) begin
              gap_cnt_reg <= '0;
              state_reg   <= ST_IDLE;
              busy_reg    <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 8'd1;
            end
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign tx_psel   = tx_psel_reg;
  assign busy      = busy_reg;
  assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Scoreboard bench for uart_tx_sched. A negedge monitor predicts each grant
// from the round-robin rule, queues the expected frame, and pops/compares it
// when tx_start appears; frame length is checked by counting baud ticks.
// Directed scenarios plus a randomized traffic phase drive the inputs.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int FT = 12;
  localparam int GT = 2;
`ifdef UART_SCHED_GAP_EN
  localparam int EXP_GAP = GT;
`else
  localparam int EXP_GAP = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_psel  = '0;
  logic [N-1:0]   req_ready;
  logic           baud_tick = 1'b0;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_psel;
  logic           busy;
  logic [1:0]     grant_id;

  uart_tx_sched #(
    .N_REQ       (N),
    .FRAME_TICKS (FT),
    .GAP_TICKS   (GT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_psel  (req_psel),
    .req_ready (req_ready),
    .baud_tick (baud_tick),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_psel   (tx_psel),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard (monitor side) -----------
  typedef struct {
    int         id;
    logic [7:0] data;
    logic       psel;
  } frame_t;

  typedef enum {P_IDLE, P_ACC, P_START, P_FRAME, P_GAP} phase_t;

  frame_t     exp_q[$];
  phase_t     m_phase;
  int         m_ptr;
  int         m_last;
  logic [7:0] m_txd;
  logic       m_psel;
  int         m_cnt;

  function automatic int rr_winner(input logic [N-1:0] v, input int last);
    for (int d = 1; d <= N; d++) begin
      if (v[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    frame_t f;
    int     w;
    if (!rst) begin
      m_phase = P_IDLE;
      m_ptr   = N - 1;
      m_last  = 0;
      m_txd   = 8'h00;
      m_psel  = 1'b0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      chk("grant_id", 32'(grant_id), 32'(m_last));
      chk("tx_data_held", 32'(tx_data), 32'(m_txd));
      chk("tx_psel_held", 32'(tx_psel), 32'(m_psel));
      case (m_phase)
        P_IDLE: begin
          chk("idle_busy", 32'(busy), 0);
          chk("idle_tx_start", 32'(tx_start), 0);
          chk("idle_req_ready", 32'(req_ready), 0);
          if (req_valid != '0) begin
            w       = rr_winner(req_valid, m_ptr);
            m_ptr   = w;
            m_last  = w;
            m_txd   = req_data[8*w +: 8];
            m_psel  = req_psel[w];
            f.id    = w;
            f.data  = m_txd;
            f.psel  = m_psel;
            exp_q.push_back(f);
            m_phase = P_ACC;
          end
        end
        P_ACC: begin
          chk("acc_req_ready", 32'(req_ready), 32'(1) << m_last);
          chk("acc_busy", 32'(busy), 1);
          chk("acc_tx_start", 32'(tx_start), 0);
          m_phase = P_START;
        end
        P_START: begin
          chk("start_tx_start", 32'(tx_start), 1);
          chk("start_busy", 32'(busy), 1);
          chk("start_req_ready", 32'(req_ready), 0);
          chk("sb_not_empty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            chk("sb_data", 32'(tx_data), 32'(f.data));
            chk("sb_psel", 32'(tx_psel), 32'(f.psel));
            chk("sb_id", 32'(grant_id), 32'(f.id));
          end
          m_cnt   = 0;
          m_phase = P_FRAME;
        end
        P_FRAME, P_GAP: begin
          chk("frame_tx_start", 32'(tx_start), 0);
          chk("frame_busy", 32'(busy), 1);
          chk("frame_req_ready", 32'(req_ready), 0);
          if (baud_tick) m_cnt++;
          if (m_phase == P_FRAME && m_cnt == FT) begin
            m_cnt   = 0;
            m_phase = (EXP_GAP > 0) ? P_GAP : P_IDLE;
          end else if (m_phase == P_GAP && m_cnt == EXP_GAP) begin
            m_cnt   = 0;
            m_phase = P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus side ----------------------------------------
  int grant_log[$];
  int ready_cnt [N];
  bit hold        = 1'b0;
  bit auto_mode   = 1'b0;
  bit withdraw_en = 1'b0;
  bit force_tick  = 1'b0;
  int tick_div    = 3;

  // One clock: observe accepts, then drive this cycle's inputs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        grant_log.push_back(i);
        ready_cnt[i]++;
        if (!hold) req_valid[i] = 1'b0;
      end
    end
    if (force_tick && (tx_start || (req_ready != '0)))
      baud_tick = 1'b1;
    else
      baud_tick = ($urandom_range(0, tick_div - 1) == 0);
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
            req_psel[i]        = 1'($urandom);
          end
        end else if (withdraw_en && ($urandom_range(0, 40) == 0)) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_ready(input string name, output int id);
    id = -1;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
        return;
      end
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!busy) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  // Lone request from one requester; checks grant, launch and frame length.
  task automatic single_frame(input string name, input int id, input logic [7:0] d, input logic p);
    int got;
    int ticks;
    bit prev_tick;
    bit done;
    req_data[8*id +: 8] = d;
    req_psel[id]        = p;
    req_valid           = '0;
    req_valid[id]       = 1'b1;
    wait_ready(name, got);
    chk({name, "_grant"}, 32'(got), 32'(id));
    step();
    chk({name, "_tx_start"}, 32'(tx_start), 1);
    chk({name, "_tx_data"}, 32'(tx_data), 32'(d));
    chk({name, "_tx_psel"}, 32'(tx_psel), 32'(p));
    ticks = 0; prev_tick = 1'b0; done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!busy) begin
        done = 1'b1;
        break;
      end
      prev_tick = baud_tick;
      if (baud_tick) ticks++;
    end
    chk({name, "_busy_fell"}, 32'(done), 1);
    chk({name, "_ticks"}, 32'(ticks), 32'(FT + EXP_GAP));
    chk({name, "_last_tick"}, 32'(prev_tick), 1);
  endtask

  initial begin
    int got;
    int r1;
    int ticks;
    int rr_exp [5] = '{0, 1, 2, 3, 0};

    for (int i = 0; i < N; i++) ready_cnt[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_psel", 32'(tx_psel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    rst = 1'b1;
    step();

    // All four continuously valid: order 0,1,2,3,0
    hold      = 1'b1;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_psel  = 4'b0101;
    grant_log.delete();
    req_valid = '1;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (grant_log.size() >= 5) break;
    end
    chk("rr_count", 32'(grant_log.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(rr_exp[k]));
    hold      = 1'b0;
    req_valid = '0;
    wait_idle("rr_idle");

    // Single request on requester 2
    single_frame("single", 2, 8'hA5, 1'b1);

    // Tick forced during the accept and start cycles is not counted
    force_tick = 1'b1;
    single_frame("launch_tick", 1, 8'h3C, 1'b0);
    force_tick = 1'b0;

    // Requester 1 withdraws while 3 holds
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    wait_ready("wd_first", got);
    chk("wd_first_grant", 32'(got), 0);
    r1 = ready_cnt[1];
    req_data[15:8]  = 8'hC1;
    req_data[31:24] = 8'hC3;
    req_valid[1]    = 1'b1;
    req_valid[3]    = 1'b1;
    repeat (3) step();
    req_valid[1] = 1'b0;
    wait_ready("wd_second", got);
    chk("wd_second_grant", 32'(got), 3);
    wait_idle("wd_idle");
    repeat (60) step();
    chk("wd_no_send_1", 32'(ready_cnt[1]), 32'(r1));

    // Randomized traffic with withdrawals
    auto_mode   = 1'b1;
    withdraw_en = 1'b1;
    repeat (3000) step();
    auto_mode   = 1'b0;
    withdraw_en = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (req_valid == '0 && !busy) break;
    end
    chk("drain_valid", 32'(req_valid), 0);
    chk("drain_busy", 32'(busy), 0);

    // Reset in the middle of a frame
    req_data[23:16] = 8'hE7;
    req_psel[2]     = 1'b1;
    req_valid       = 4'b0100;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (tx_start) break;
    end
    chk("mid_rst_started", 32'(tx_start), 1);
    ticks = 0;
    for (int k = 0; k < 3000 && ticks < 5; k++) begin
      step();
      if (baud_tick) ticks++;
    end
    chk("mid_rst_busy_before", 32'(busy), 1);
    #2;
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_tx_psel", 32'(tx_psel), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    repeat (3) step();
    rst       = 1'b1;
    req_data  = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
    grant_log.delete();
    req_valid = '1;
    wait_ready("post_rst", got);
    chk("post_rst_first", 32'(got), 0);
    req_valid = '0;
    wait_idle("post_rst_idle");
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
